spi_rx_deserializer: RTL and testbench
======================================

Name: spi_rx_deserializer

Overview:
Receive half of the SPI master: the serial-to-parallel path that mirrors the transmit parallel-to-serial chain. It captures MISO one bit per sample strobe from the master's SCLK generator and assembles WIDTH-bit words. Each completed word goes into an output holding register with a valid/ready handshake and overrun detection. It sits beside the transmit shift chain and is started by the same frame-start pulse.

Parameters:
WIDTH, 8, word length in bits (2..32)
MSB_FIRST, 1, 1 = first received bit lands in data_out[WIDTH-1]; 0 = first bit lands in data_out[0]

Ports:
clk_in  input  1  system clock; all state changes on rising edge
rst_in  input  1  asynchronous, active-high reset
start_in  input  1  one-cycle pulse that begins a frame
sample_in  input  1  one-cycle strobe marking the SCLK sampling edge
miso_in  input  1  serial data from the slave, already synchronised to clk_in
ready_in  input  1  consumer accepts data_out when valid_out=1
clear_in  input  1  clears sticky overrun_out
data_out  output  WIDTH  last completed word
valid_out  output  1  data_out holds an unconsumed word
busy_out  output  1  frame in progress
done_out  output  1  one-cycle pulse when a word completes
overrun_out  output  1  sticky flag: a word was dropped

Behaviour:
- Reset (asynchronous, any time, including mid-frame) clears all of the following:
  - data_out=0, valid_out=0, busy_out=0, done_out=0, overrun_out=0.
  - The shift register and bit counter (width $clog2(WIDTH)).
  - FSM returns to IDLE.
- FSM has two states, IDLE and SHIFT.
  - IDLE: on start_in=1, go to SHIFT, set bit_cnt=0, clear the shift register, set busy_out=1 on the next edge. sample_in is ignored in IDLE.
  - SHIFT: on each sample_in=1, shift miso_in in and increment bit_cnt.
    - MSB_FIRST=1: shift toward the MSB, new bit enters bit 0.
    - MSB_FIRST=0: shift toward the LSB, new bit enters bit WIDTH-1.
  - SHIFT: when sample_in=1 and bit_cnt==WIDTH-1, the word completes on that edge.
    - The FSM returns to IDLE and busy_out drops.
    - done_out=1 for exactly that one following cycle.
  - start_in while in SHIFT is ignored; the frame is not restarted.
  - start_in and sample_in together in IDLE: start wins, and that sample is not captured.
- Latency: the assembled word, including the last bit, is visible on data_out after the same clk_in edge that samples the last bit. No extra pipeline stage.
- Output handshake:
  - A word is consumed on an edge where valid_out=1 and ready_in=1.
  - valid_out falls after consumption unless a new word loads on the same edge.
  - data_out is stable while valid_out=1 and the word has not been consumed.
- Completion events:
  - Completion with valid_out=0: load data_out, set valid_out=1.
  - Completion with valid_out=1 and ready_in=1 on the same edge: load the new word, valid_out stays 1, no overrun.
  - Completion with valid_out=1 and ready_in=0: drop the new word, keep the old data_out, set overrun_out=1. done_out still pulses.
- overrun_out stays set until clear_in=1. If clear_in and a new overrun occur on the same edge, set wins.
- sample_in held high on consecutive cycles captures one bit per cycle; there is no minimum spacing.

Decomposition:
- Shared SPI package holds:
  - FSM state encodings (ST_IDLE=1'b0, ST_SHIFT=1'b1).
  - Default WIDTH constant, shared with the transmit chain so both directions agree on frame length.
- Sub-module serial_to_par_cell: one storage bit with enable and a choice of shift-in or clear.
  - Instantiated WIDTH times by a generate loop.
  - Mirrors the transmit cell chain structurally.
- FSM, counter and output buffer live in the top module.

Test Plan:
- Reset mid-frame: WIDTH=8, start, 3 samples, assert rst_in asynchronously -> all outputs 0 immediately; a following start then 8 samples of 0xA5 gives data_out=0xA5.
- MSB_FIRST=1, miso sequence 1,0,1,0,0,1,0,1 on 8 spaced samples, ready_in=1 -> data_out=0xA5, valid_out=1 and done_out=1 on the edge after the 8th sample, busy_out=0; valid_out falls the next cycle.
- MSB_FIRST=0, same sequence -> data_out=0xA5 bit-reversed = 0xA5 check with 1,1,0,0,0,0,0,0 -> data_out=0x03.
- Back-to-back frames with sample_in held high, ready_in=1 exactly on the second completion edge -> second word loads, valid_out stays 1, overrun_out=0.
- Two frames with ready_in=0 (0x3C then 0xC3) -> data_out remains 0x3C, overrun_out=1 and sticky; clear_in pulse -> overrun_out=0.
- start_in pulsed during SHIFT at bit 4, and start with simultaneous sample in IDLE -> frame is not restarted and exactly 8 bits are captured after the accepted start.

Source files
------------

// File: rtl/spi_rx_deserializer_pkg.sv
// Definitions shared by the SPI master's transmit and receive shift chains.
// Both directions must agree on the frame length through SPI_WIDTH.
package spi_rx_deserializer_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } spi_state_t;

    localparam int SPI_WIDTH = 8;

endpackage

// File: rtl/spi_rx_deserializer_serial_to_par_cell.sv
// One storage bit of the receive shift chain; either loads its shift input
// or clears, and only when enabled.
module serial_to_par_cell (
    input  logic clk_in,
    input  logic rst_in,
    input  logic en_in,
    input  logic clr_in,
    input  logic d_in,
    output logic q_out
);

    // storage bit: clear takes priority over shift-in when enabled
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            q_out <= 1'b0;
        end else if (en_in) begin
            q_out <= clr_in ? 1'b0 : d_in;
        end
    end

endmodule

// File: rtl/spi_rx_deserializer.sv
// SPI master receive path: assembles WIDTH-bit words from MISO on sample
// strobes and hands them out through a valid/ready holding register.
module spi_rx_deserializer
    import spi_rx_deserializer_pkg::*;
#(
    parameter int WIDTH     = SPI_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             start_in,
    input  logic             sample_in,
    input  logic             miso_in,
    input  logic             ready_in,
    input  logic             clear_in,
    output logic [WIDTH-1:0] data_out,
    output logic             valid_out,
    output logic             busy_out,
    output logic             done_out,
    output logic             overrun_out
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    spi_state_t       state_r;
    spi_state_t       state_nxt_s;
    logic [CNT_W-1:0] bit_cnt_r;
    logic [WIDTH-1:0] shift_q_s;
    logic [WIDTH-1:0] shift_nxt_s;
    logic [WIDTH-1:0] data_r;
    logic             valid_r;
    logic             done_r;
    logic             overrun_r;
    logic             frame_start_s;
    logic             shift_en_s;
    logic             complete_s;
    logic             cell_en_s;
    logic             drop_s;

    // frame control strobes derived from the current state
    always_comb begin
        frame_start_s = 1'b0;
        shift_en_s    = 1'b0;
        if (state_r == ST_IDLE) begin
            frame_start_s = start_in;
        end else begin
            shift_en_s = sample_in;
        end
        complete_s = shift_en_s && (bit_cnt_r == LAST_CNT);
        cell_en_s  = frame_start_s || shift_en_s;
        drop_s     = complete_s && valid_r && !ready_in;
    end

    // next contents of the chain: new bit enters at the end opposite the shift direction
    always_comb begin
        shift_nxt_s = shift_q_s;
        if (MSB_FIRST) begin
            shift_nxt_s = {shift_q_s[WIDTH-2:0], miso_in};
        end else begin
            shift_nxt_s = {miso_in, shift_q_s[WIDTH-1:1]};
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        serial_to_par_cell u_cell (
            .clk_in (clk_in),
            .rst_in (rst_in),
            .en_in  (cell_en_s),
            .clr_in (frame_start_s),
            .d_in   (shift_nxt_s[i]),
            .q_out  (shift_q_s[i])
        );
    end

    // next-state logic; start is ignored once a frame is running
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_in) begin
                    state_nxt_s = ST_SHIFT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (complete_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_SHIFT;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // bit counter, reset at frame start and after the last bit
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            bit_cnt_r <= {CNT_W{1'b0}};
        end else if (frame_start_s || complete_s) begin
            bit_cnt_r <= {CNT_W{1'b0}};
        end else if (shift_en_s) begin
            bit_cnt_r <= bit_cnt_r + CNT_W'(1);
        end
    end

    // output holding register; a completed word is dropped only if the old one is still unclaimed
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            data_r    <= {WIDTH{1'b0}};
            valid_r   <= 1'b0;
            done_r    <= 1'b0;
            overrun_r <= 1'b0;
        end else begin
            done_r <= complete_s;
            if (complete_s && !drop_s) begin
                data_r  <= shift_nxt_s;
                valid_r <= 1'b1;
            end else if (valid_r && ready_in) begin
                valid_r <= 1'b0;
            end
            if (drop_s) begin
                overrun_r <= 1'b1;
            end else if (clear_in) begin
                overrun_r <= 1'b0;
            end
        end
    end

    assign data_out    = data_r;
    assign valid_out   = valid_r;
    assign busy_out    = (state_r == ST_SHIFT);
    assign done_out    = done_r;
    assign overrun_out = overrun_r;

endmodule

// File: tb/tb_spi_rx_deserializer.sv
// Scoreboard bench for spi_rx_deserializer: an MSB-first and an LSB-first
// instance share stimulus; each completed word is checked against a queue.
module tb_spi_rx_deserializer;

    localparam int W = 8;

    typedef struct {
        logic [W-1:0] msb;
        logic [W-1:0] lsb;
        logic         ovr;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic sample = 1'b0;
    logic miso = 1'b0;
    logic ready = 1'b0;
    logic clear = 1'b0;

    logic [W-1:0] data_m, data_l;
    logic valid_m, valid_l, busy_m, busy_l, done_m, done_l, ovr_m, ovr_l;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    spi_rx_deserializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_dut_msb (
        .clk_in(clk), .rst_in(rst), .start_in(start), .sample_in(sample),
        .miso_in(miso), .ready_in(ready), .clear_in(clear),
        .data_out(data_m), .valid_out(valid_m), .busy_out(busy_m),
        .done_out(done_m), .overrun_out(ovr_m)
    );

    spi_rx_deserializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_dut_lsb (
        .clk_in(clk), .rst_in(rst), .start_in(start), .sample_in(sample),
        .miso_in(miso), .ready_in(ready), .clear_in(clear),
        .data_out(data_l), .valid_out(valid_l), .busy_out(busy_l),
        .done_out(done_l), .overrun_out(ovr_l)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Frame: start cycle (sample=hold, miso set to the wrong bit), then 8 samples of w MSB first.
    task automatic send_frame(input logic [W-1:0] w, input bit gap, input bit hold,
                              input int start_at, input int rdy_last,
                              input logic [W-1:0] e_msb, input logic [W-1:0] e_lsb,
                              input logic e_ovr);
        exp_t e;
        e.msb = e_msb;
        e.lsb = e_lsb;
        e.ovr = e_ovr;
        exp_q.push_back(e);
        start  = 1'b1;
        sample = hold;
        miso   = ~w[W-1];
        tick();
        start = 1'b0;
        if (gap) begin
            sample = 1'b0;
            tick();
        end
        for (int i = 0; i < W; i++) begin
            sample = 1'b1;
            miso   = w[W-1-i];
            start  = (i == start_at);
            if (i == W - 1 && rdy_last >= 0) ready = rdy_last[0];
            tick();
            start = 1'b0;
            if (gap && i < W - 1) begin
                sample = 1'b0;
                tick();
            end
        end
        sample = 1'b0;
    endtask

    // Monitor: every done pulse must match the next expected completion.
    always @(negedge clk) begin
        if (!rst && (done_m || done_l)) begin
            check("done_pair", {31'd0, done_l}, {31'd0, done_m});
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("data_msb_first", {24'd0, data_m}, {24'd0, e.msb});
                check("data_lsb_first", {24'd0, data_l}, {24'd0, e.lsb});
                check("valid_on_done", {31'd0, valid_m}, 32'd1);
                check("busy_on_done", {31'd0, busy_m}, 32'd0);
                check("overrun_on_done", {31'd0, ovr_m}, {31'd0, e.ovr});
            end
        end
    end

    initial begin
        tick();
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("rst_data", {24'd0, data_m}, 32'd0);
        check("rst_valid", {31'd0, valid_m}, 32'd0);
        check("rst_busy", {31'd0, busy_m}, 32'd0);
        check("rst_done", {31'd0, done_m}, 32'd0);
        check("rst_overrun", {31'd0, ovr_m}, 32'd0);

        // Spaced 0xA5 with ready high; valid must fall the cycle after done.
        ready = 1'b1;
        send_frame(8'hA5, 1'b1, 1'b0, -1, -1, 8'hA5, 8'hA5, 1'b0);
        @(negedge clk);
        tick();
        @(negedge clk);
        check("valid_falls", {31'd0, valid_m}, 32'd0);
        check("done_one_cycle", {31'd0, done_m}, 32'd0);

        // 1,1,0,0,0,0,0,0: 0xC0 MSB-first, 0x03 LSB-first.
        send_frame(8'hC0, 1'b1, 1'b0, -1, -1, 8'hC0, 8'h03, 1'b0);
        tick();
        tick();

        // Back-to-back frames with sample held high; ready only on the second completion.
        ready = 1'b0;
        send_frame(8'h12, 1'b0, 1'b1, -1, -1, 8'h12, 8'h48, 1'b0);
        send_frame(8'hE8, 1'b0, 1'b1, -1, 1, 8'hE8, 8'h17, 1'b0);
        ready = 1'b0;
        @(negedge clk);
        tick();
        @(negedge clk);
        check("b2b_valid_held", {31'd0, valid_m}, 32'd1);
        check("b2b_data_held", {24'd0, data_m}, 32'h0000_00E8);
        check("b2b_no_overrun", {31'd0, ovr_m}, 32'd0);
        ready = 1'b1;
        tick();
        ready = 1'b0;
        @(negedge clk);
        check("b2b_consumed", {31'd0, valid_m}, 32'd0);

        // Overrun: second word dropped while the first is unclaimed.
        send_frame(8'h3C, 1'b1, 1'b0, -1, -1, 8'h3C, 8'h3C, 1'b0);
        send_frame(8'hC3, 1'b1, 1'b0, -1, -1, 8'h3C, 8'h3C, 1'b1);
        @(negedge clk);
        tick();
        tick();
        @(negedge clk);
        check("overrun_sticky", {31'd0, ovr_m}, 32'd1);
        check("overrun_data_kept", {24'd0, data_m}, 32'h0000_003C);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        @(negedge clk);
        check("overrun_cleared", {31'd0, ovr_m}, 32'd0);
        check("valid_after_clear", {31'd0, valid_m}, 32'd1);

        // Asynchronous reset mid-frame while a word is still held.
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sample = 1'b1;
            miso   = 1'b1;
            tick();
        end
        sample = 1'b0;
        @(negedge clk);
        check("busy_before_rst", {31'd0, busy_m}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_data", {24'd0, data_m}, 32'd0);
        check("async_rst_valid", {31'd0, valid_m}, 32'd0);
        check("async_rst_busy", {31'd0, busy_m}, 32'd0);
        check("async_rst_overrun", {31'd0, ovr_m}, 32'd0);
        tick();
        rst = 1'b0;
        ready = 1'b1;
        send_frame(8'hA5, 1'b1, 1'b0, -1, -1, 8'hA5, 8'hA5, 1'b0);
        tick();
        tick();

        // Start with sample in IDLE, and a stray start at bit 4: no restart.
        send_frame(8'h96, 1'b1, 1'b1, 4, -1, 8'h96, 8'h69, 1'b0);
        for (int i = 0; i < 12; i++) tick();
        @(negedge clk);
        check("no_extra_done", {31'd0, done_m}, 32'd0);
        check("idle_after_frames", {31'd0, busy_m}, 32'd0);
        check("all_words_seen", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
